// File: rtl/grad_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// grad_read_arbiter_if
// Bundles the requester-side and BRAM-side signals of grad_read_arbiter.
//   req_in/lock_in/addr_in : per-requester read request, burst lock, address
//   gnt_out                : one-hot combinational grant
//   bram_addr_out          : shared address to the x-grad/y-grad BRAM pair
//   bram_x_in/bram_y_in    : BRAM douta words
//   rvalid_out             : one-hot read-data valid, READ_LATENCY after grant
//   rdata_x_out/rdata_y_out: signed read data, zero when no valid
// Modports: slave = arbiter, master = requesters/BRAM environment.
// ---------------------------------------------------------------------------
interface grad_read_arbiter_if #(
  parameter int BIT_DEPTH = 8,
  parameter int DIMENSION = 64,
  parameter int NUM_REQ   = 2,
  localparam int ADDR_W   = $clog2(DIMENSION*DIMENSION)
);
  logic [NUM_REQ-1:0]        req_in;
  logic [NUM_REQ-1:0]        lock_in;
  logic [NUM_REQ*ADDR_W-1:0] addr_in;
  logic [NUM_REQ-1:0]        gnt_out;
  logic [ADDR_W-1:0]         bram_addr_out;
  logic signed [BIT_DEPTH-1:0] bram_x_in;
  logic signed [BIT_DEPTH-1:0] bram_y_in;
  logic [NUM_REQ-1:0]        rvalid_out;
  logic signed [BIT_DEPTH-1:0] rdata_x_out;
  logic signed [BIT_DEPTH-1:0] rdata_y_out;

  modport slave (
    input  req_in, lock_in, addr_in, bram_x_in, bram_y_in,
    output gnt_out, bram_addr_out, rvalid_out, rdata_x_out, rdata_y_out
  );

  modport master (
    output req_in, lock_in, addr_in, bram_x_in, bram_y_in,
    input  gnt_out, bram_addr_out, rvalid_out, rdata_x_out, rdata_y_out
  );
endinterface

// File: rtl/grad_read_arbiter.sv
// ---------------------------------------------------------------------------
// grad_read_arbiter
// Shares one gradient BRAM pair (common read address) between NUM_REQ
// requesters with round-robin arbitration and an optional burst lock, and
// routes each read word back to its issuer READ_LATENCY cycles after grant.
// Ports:
//   clk_in          : system clock, rising edge
//   rst_in          : synchronous active-high reset
//   bus             : grad_read_arbiter_if.slave (requests, grant, BRAM, rdata)
//   lock_owner_out  : index of current lock holder
//   locked_out      : lock held
//   stall_count_out : cycles with a pending, ungranted request (saturating)
// Optional feature: define GRAD_ARB_STATS_EN to build the stall counter;
// otherwise stall_count_out is tied to zero.
// ---------------------------------------------------------------------------
module grad_read_arbiter #(
  parameter int BIT_DEPTH    = 8,
  parameter int DIMENSION    = 64,
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 2,
  localparam int ADDR_W      = $clog2(DIMENSION*DIMENSION),
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  grad_read_arbiter_if.slave bus,
  output logic [IDX_W-1:0] lock_owner_out,
  output logic             locked_out,
  output logic [15:0]      stall_count_out
);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (int'(i) == NUM_REQ-1) return '0;
    else                      return i + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    else               return v + 16'd1;
  endfunction

  logic [IDX_W-1:0]  r_rr;
  logic              r_locked;
  logic [IDX_W-1:0]  r_owner;
  logic [ADDR_W-1:0] r_addr;

  logic [NUM_REQ-1:0] w_gnt;
  logic               w_gnt_any;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_release;
  int                 w_cand;
  logic [IDX_W-1:0]   w_cand_idx;
  logic [ADDR_W-1:0]  w_addr_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign w_addr_arr[g] = bus.addr_in[g*ADDR_W +: ADDR_W];
  end

  // ---- arbitration (combinational grant) ----
  always_comb begin
    w_gnt      = '0;
    w_gnt_any  = 1'b0;
    w_gnt_idx  = '0;
    w_release  = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    if (!rst_in) begin
      if (r_locked) begin
        // Only the owner may be served; its absent request ends the burst
        // and that cycle grants nothing.
        if (bus.req_in[r_owner]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = r_owner;
        end else begin
          w_release = 1'b1;
        end
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          w_cand = int'(r_rr) + k;
          if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
          w_cand_idx = IDX_W'(w_cand);
          if (!w_gnt_any && bus.req_in[w_cand_idx]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = w_cand_idx;
          end
        end
      end
      if (w_gnt_any) w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  assign bus.gnt_out       = w_gnt;
  // Address follows the grant immediately so the BRAM latency starts in the
  // grant cycle; otherwise hold the last address.
  assign bus.bram_addr_out = w_gnt_any ? w_addr_arr[w_gnt_idx] : r_addr;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rr     <= '0;
      r_locked <= 1'b0;
      r_owner  <= '0;
      r_addr   <= '0;
    end else begin
      if (w_release) begin
        r_locked <= 1'b0;
        r_rr     <= next_idx(r_owner);
      end else if (w_gnt_any) begin
        if (bus.lock_in[w_gnt_idx]) begin
          r_locked <= 1'b1;
          r_owner  <= w_gnt_idx;
        end else begin
          r_locked <= 1'b0;
          r_rr     <= next_idx(w_gnt_idx);
        end
      end
      if (w_gnt_any) r_addr <= w_addr_arr[w_gnt_idx];
    end
  end

  assign lock_owner_out = r_owner;
  assign locked_out     = r_locked;

  // ---- tag pipeline: stage _p[0] loads at grant, shifts every cycle ----
  logic [READ_LATENCY-1:0] r_vld_p;
  logic [IDX_W-1:0]        r_id_p [READ_LATENCY];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= w_gnt_any;
      for (int s = 1; s < READ_LATENCY; s++) r_vld_p[s] <= r_vld_p[s-1];
    end
  end

  always_ff @(posedge clk_in) begin
    r_id_p[0] <= w_gnt_idx;
    for (int s = 1; s < READ_LATENCY; s++) r_id_p[s] <= r_id_p[s-1];
  end

  // ---- return path: final tag stage steers BRAM data to its requester ----
  always_comb begin
    bus.rvalid_out  = '0;
    bus.rdata_x_out = '0;
    bus.rdata_y_out = '0;
    // Masked during reset so reads granted before reset never surface.
    if (!rst_in && r_vld_p[READ_LATENCY-1]) begin
      bus.rvalid_out[r_id_p[READ_LATENCY-1]] = 1'b1;
      bus.rdata_x_out = bus.bram_x_in;
      bus.rdata_y_out = bus.bram_y_in;
    end
  end

`ifdef GRAD_ARB_STATS_EN
  logic        w_stall;
  logic [15:0] r_stall_cnt;

  assign w_stall = |(bus.req_in & ~w_gnt);

  always_ff @(posedge clk_in) begin
    if (rst_in)       r_stall_cnt <= '0;
    else if (w_stall) r_stall_cnt <= sat_inc16(r_stall_cnt);
  end

  assign stall_count_out = r_stall_cnt;
`else
  assign stall_count_out = '0;
`endif

endmodule
